// File: rtl/queue_pkg.sv
// Shared definitions for the queue round-robin arbiter: default sizes and
// the two-state control encoding.
package queue_pkg;

    localparam int W_DEFAULT     = 8;
    localparam int DEPTH_DEFAULT = 16;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after
// rr_ptr, wrapping modulo N.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic          any,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    localparam logic [IW:0] NV = (IW+1)'(N);

    always_comb begin
        logic [IW:0] pos;
        pos    = '0;
        any    = 1'b0;
        onehot = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            // one extra bit so rr_ptr + k can be folded back into 0..N-1
            pos = {1'b0, rr_ptr} + (IW+1)'(k);
            if (pos >= NV) begin
                pos = pos - NV;
            end
            if (!any && req[pos[IW-1:0]]) begin
                any                 = 1'b1;
                onehot[pos[IW-1:0]] = 1'b1;
                idx                 = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/queue_rr_arbiter.sv
// Shares one FIFO between N producers (round-robin push side) and a
// valid/ready consumer, with a flush mode that drains the queue.
module queue_rr_arbiter
    import queue_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int W     = W_DEFAULT,
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int CW    = $clog2(DEPTH+1),
    localparam int IW    = $clog2(N)
) (
    input  logic          m_clock,
    input  logic          p_reset,
    input  logic [N-1:0]  req,
    input  logic [N*W-1:0] din,
    output logic [N-1:0]  gnt,
    output logic [W-1:0]  q_in,
    output logic          q_push,
    output logic          q_pop,
    input  logic [W-1:0]  q_out,
    input  logic          q_is_empty,
    output logic          deq_valid,
    input  logic          deq_ready,
    output logic [W-1:0]  deq_data,
    input  logic          flush,
    output logic          busy_flush,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [IW-1:0] LAST = IW'(N-1);

    state_t        state;
    state_t        next_state;
    logic [IW-1:0] rr_ptr;
    logic          pick_any;
    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] pick_idx;
    logic [W-1:0]  din_arr [N];
    logic          grant_now;

    rr_pick #(.N(N)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            din_arr[i] = din[i*W +: W];
        end
    end

    // A flush request on the same edge suppresses the grant; no bypass when full.
    assign grant_now = (state == ST_RUN) && !flush && pick_any && (count < FULL);

    always_comb begin
        next_state = state;
        deq_valid  = 1'b0;
        q_pop      = 1'b0;
        busy_flush = 1'b0;
        deq_data   = q_out;
        case (state)
            ST_RUN: begin
                deq_valid = ~q_is_empty;
                q_pop     = ~q_is_empty & deq_ready;
                if (flush) begin
                    next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy_flush = 1'b1;
                q_pop      = ~q_is_empty;
                if (q_is_empty && !q_push && (count == '0)) begin
                    next_state = ST_RUN;
                end
            end
            default: next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            state  <= ST_RUN;
            gnt    <= '0;
            q_in   <= '0;
            q_push <= 1'b0;
            rr_ptr <= '0;
            count  <= '0;
        end else begin
            state <= next_state;
            if (grant_now) begin
                gnt    <= pick_onehot;
                q_in   <= din_arr[pick_idx];
                q_push <= 1'b1;
                rr_ptr <= (pick_idx == LAST) ? '0 : pick_idx + IW'(1);
            end else begin
                gnt    <= '0;
                q_push <= 1'b0;
            end
            case ({grant_now, q_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    count_no_overflow: assert property (@(posedge m_clock) disable iff (p_reset)
        !(grant_now && !q_pop && (count == FULL)));
    count_no_underflow: assert property (@(posedge m_clock) disable iff (p_reset)
        !(q_pop && !grant_now && (count == '0)));

endmodule

// File: tb/tb_queue_rr_arbiter.sv
// Self-checking bench: arbiter plus a behavioural queue, compared cycle by
// cycle against a queue-based reference model of the arbitration rules.
module tb_queue_rr_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 16;

    logic         m_clock;
    logic         p_reset;
    logic [3:0]   req;
    logic [31:0]  din;
    logic [3:0]   gnt;
    logic [7:0]   q_in;
    logic         q_push;
    logic         q_pop;
    logic [7:0]   q_out;
    logic         q_is_empty;
    logic         deq_valid;
    logic         deq_ready;
    logic [7:0]   deq_data;
    logic         flush;
    logic         busy_flush;
    logic [4:0]   count;

    queue_rr_arbiter #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .m_clock    (m_clock),
        .p_reset    (p_reset),
        .req        (req),
        .din        (din),
        .gnt        (gnt),
        .q_in       (q_in),
        .q_push     (q_push),
        .q_pop      (q_pop),
        .q_out      (q_out),
        .q_is_empty (q_is_empty),
        .deq_valid  (deq_valid),
        .deq_ready  (deq_ready),
        .deq_data   (deq_data),
        .flush      (flush),
        .busy_flush (busy_flush),
        .count      (count)
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    // The queue instance the arbiter drives: 16-entry FIFO, head shown combinationally.
    logic [7:0] qmem [DEPTH];
    logic [3:0] rd_ptr;
    logic [3:0] wr_ptr;
    logic [4:0] qcnt;

    always @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            qcnt   <= '0;
        end else begin
            if (q_pop && qcnt != 0) rd_ptr <= rd_ptr + 4'd1;
            if (q_push) begin
                qmem[wr_ptr] <= q_in;
                wr_ptr       <= wr_ptr + 4'd1;
            end
            qcnt <= qcnt + 5'(q_push) - 5'(q_pop && qcnt != 0);
        end
    end

    assign q_out      = qmem[rd_ptr];
    assign q_is_empty = (qcnt == 0);

    int checks = 0;
    int errors = 0;

    // Reference model: bytes physically queued, a granted byte still in flight,
    // the committed count, pointer and flush flag as plain integers.
    logic [7:0] m_fifo [$];
    bit         m_pend;
    logic [7:0] m_pend_byte;
    int         m_cnt;
    int         m_ptr;
    bit         m_flush;
    logic [3:0] m_gnt;
    int         pop_seen;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_fifo.delete();
        m_pend      = 1'b0;
        m_pend_byte = '0;
        m_cnt       = 0;
        m_ptr       = 0;
        m_flush     = 1'b0;
        m_gnt       = '0;
    endtask

    task automatic doReset();
        @(negedge m_clock);
        p_reset   = 1'b1;
        req       = '0;
        din       = '0;
        deq_ready = 1'b0;
        flush     = 1'b0;
        @(negedge m_clock);
        checkOutput("rst_gnt", int'(gnt), 0);
        checkOutput("rst_q_push", int'(q_push), 0);
        checkOutput("rst_q_in", int'(q_in), 0);
        checkOutput("rst_count", int'(count), 0);
        checkOutput("rst_busy", int'(busy_flush), 0);
        checkOutput("rst_deq_valid", int'(deq_valid), 0);
        p_reset = 1'b0;
        modelReset();
    endtask

    // Drive one cycle of inputs, check the combinational pop side, then the
    // registered results of the following edge.
    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d,
                                 input logic rdy, input logic fl);
        int  win;
        bit  empty;
        bit  pop;
        bit  grant;
        bit  leave;
        @(negedge m_clock);
        req       = r;
        din       = d;
        deq_ready = rdy;
        flush     = fl;
        #1;
        empty = (m_fifo.size() == 0);
        pop   = m_flush ? !empty : (!empty && rdy);
        checkOutput("deq_valid", int'(deq_valid), int'(!m_flush && !empty));
        checkOutput("q_pop", int'(q_pop), int'(pop));
        if (!m_flush && !empty) checkOutput("deq_data", int'(deq_data), int'(m_fifo[0]));
        if (q_pop) pop_seen++;
        win = -1;
        if (!m_flush && !fl && m_cnt < DEPTH) begin
            for (int k = 0; k < N; k++) begin
                int i = (m_ptr + k) % N;
                if (win < 0 && r[i]) win = i;
            end
        end
        grant = (win >= 0);
        leave = m_flush && empty && !m_pend && (m_cnt == 0);
        @(posedge m_clock);
        #1;
        if (pop) void'(m_fifo.pop_front());
        if (m_pend) m_fifo.push_back(m_pend_byte);
        m_pend = grant;
        m_gnt  = '0;
        if (grant) begin
            m_pend_byte = d[win*8 +: 8];
            m_ptr       = (win + 1) % N;
            m_gnt       = 4'(1 << win);
            m_cnt++;
        end
        if (pop) m_cnt--;
        if (!m_flush && fl) m_flush = 1'b1;
        else if (leave) m_flush = 1'b0;
        checkOutput("gnt", int'(gnt), int'(m_gnt));
        checkOutput("q_push", int'(q_push), int'(m_pend));
        if (m_pend) checkOutput("q_in", int'(q_in), int'(m_pend_byte));
        checkOutput("count", int'(count), m_cnt);
        checkOutput("busy_flush", int'(busy_flush), int'(m_flush));
    endtask

    initial begin
        int gc [4];
        int guard;
        p_reset   = 1'b1;
        req       = '0;
        din       = '0;
        deq_ready = 1'b0;
        flush     = 1'b0;
        pop_seen  = 0;
        modelReset();
        doReset();

        // single producer, three bytes, then drain in order
        applyStimulus(4'b0001, 32'd7, 1'b0, 1'b0);
        applyStimulus(4'b0001, 32'd2, 1'b0, 1'b0);
        applyStimulus(4'b0001, 32'd3, 1'b0, 1'b0);
        applyStimulus(4'b0000, 32'd0, 1'b0, 1'b0);
        checkOutput("s1_count", int'(count), 3);
        for (int c = 0; c < 4; c++) applyStimulus(4'b0000, 32'd0, 1'b1, 1'b0);
        checkOutput("s1_drained", int'(count), 0);

        // all producers until full: four grants each in rotation
        doReset();
        for (int i = 0; i < 4; i++) gc[i] = 0;
        for (int c = 0; c < 16; c++) begin
            applyStimulus(4'b1111, $urandom(), 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) gc[i] += int'(gnt[i]);
        end
        for (int i = 0; i < 4; i++) checkOutput("s2_grants_each", gc[i], 4);
        applyStimulus(4'b1111, $urandom(), 1'b0, 1'b0);
        checkOutput("s2_full_count", int'(count), 16);
        checkOutput("s2_full_gnt", int'(gnt), 0);

        // pop while full: no bypass, the grant follows one edge later
        applyStimulus(4'b1111, $urandom(), 1'b1, 1'b0);
        checkOutput("s3_pop_count", int'(count), 15);
        checkOutput("s3_pop_gnt", int'(gnt), 0);
        applyStimulus(4'b1111, $urandom(), 1'b0, 1'b0);
        checkOutput("s3_regrant_count", int'(count), 16);
        checkOutput("s3_regrant_any", int'(gnt != 0), 1);

        // same-cycle push and pop at count 5
        for (int c = 0; c < 11; c++) applyStimulus(4'b0000, 32'd0, 1'b1, 1'b0);
        checkOutput("s4_count5", int'(count), 5);
        applyStimulus(4'b0001, $urandom(), 1'b1, 1'b0);
        checkOutput("s4_push_pop", int'(count), 5);
        for (int c = 0; c < 8; c++) applyStimulus(4'b0000, 32'd0, 1'b1, 1'b0);
        checkOutput("s4_empty", int'(count), 0);

        // flush ten entries while producer 1 keeps requesting
        for (int c = 0; c < 10; c++) applyStimulus(4'b0100, $urandom(), 1'b0, 1'b0);
        applyStimulus(4'b0000, 32'd0, 1'b0, 1'b0);
        checkOutput("s5_count10", int'(count), 10);
        pop_seen = 0;
        applyStimulus(4'b0010, $urandom(), 1'b0, 1'b1);
        checkOutput("s5_busy", int'(busy_flush), 1);
        guard = 0;
        while (m_flush && guard < 40) begin
            applyStimulus(4'b0010, $urandom(), 1'b1, 1'b0);
            guard++;
        end
        checkOutput("s5_flush_bound", int'(guard < 40), 1);
        checkOutput("s5_flush_pops", pop_seen, 10);
        checkOutput("s5_busy_done", int'(busy_flush), 0);
        applyStimulus(4'b0010, $urandom(), 1'b0, 1'b0);
        checkOutput("s5_resume_gnt", int'(gnt), 2);
        for (int c = 0; c < 3; c++) applyStimulus(4'b0000, 32'd0, 1'b1, 1'b0);

        // asynchronous reset in the middle of a burst
        doReset();
        for (int c = 0; c < 6; c++) applyStimulus(4'b1111, $urandom(), 1'b0, 1'b0);
        checkOutput("s6_count6", int'(count), 6);
        checkOutput("s6_push_live", int'(q_push), 1);
        #2;
        p_reset = 1'b1;
        #1;
        checkOutput("s6_async_gnt", int'(gnt), 0);
        checkOutput("s6_async_push", int'(q_push), 0);
        checkOutput("s6_async_q_in", int'(q_in), 0);
        checkOutput("s6_async_count", int'(count), 0);
        checkOutput("s6_async_busy", int'(busy_flush), 0);
        @(negedge m_clock);
        p_reset = 1'b0;
        req     = '0;
        modelReset();
        applyStimulus(4'b1111, $urandom(), 1'b0, 1'b0);
        checkOutput("s6_first_gnt", int'(gnt), 1);

        // randomized traffic with occasional flush pulses
        for (int c = 0; c < 400; c++) begin
            applyStimulus(4'($urandom_range(0, 15)), $urandom(),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
